mips_divider: RTL

//  Multi-cycle restoring shift-subtract divider for the MIPS32 DIV/DIVU instructions.
//  It is the inverse arithmetic path to the ripple adder/subtractor: it consumes

---
 rtl/mips_divider_pkg.sv | 14 +
 rtl/mips_divider_if.sv | 38 +++
 rtl/mips_divider_step.sv | 35 +++
 rtl/mips_divider.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mips_divider_pkg.sv
// Shared definitions for the MIPS32 DIV/DIVU divider slice.
// Holds the default datapath width (common with the ALU) and the FSM state type.
package mips_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/mips_divider_if.sv
// Request/result bundle between the core and the divider.
// The optional abort line exists only when DIVIDER_ABORT_EN is defined.
interface mips_divider_if
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             sign_en;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIVIDER_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, sign_en, dividend, divisor,
`ifdef DIVIDER_ABORT_EN
    output abort,
`endif
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, sign_en, dividend, divisor,
`ifdef DIVIDER_ABORT_EN
    input  abort,
`endif
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/mips_divider_step.sv
// One restoring-division step: shift {R,Q} left by one, subtract the divisor
// from the widened partial remainder on a ripple borrow chain, and keep the
// difference only when no borrow comes out of the top.
module mips_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_rNext,
  output logic [WIDTH-1:0] o_qNext
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_subB;
  logic [WIDTH-1:0] w_diff;
  logic             w_carry;

  // Ripple subtract (A + ~B + 1); final carry set means shifted R >= D
  always_comb begin
    w_shift = {i_r, i_q[WIDTH-1]};
    w_subB  = ~{1'b0, i_d};
    w_diff  = '0;
    w_carry = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i < WIDTH) begin
        w_diff[i] = w_shift[i] ^ w_subB[i] ^ w_carry;
      end
      w_carry = (w_shift[i] & w_subB[i]) | (w_carry & (w_shift[i] ^ w_subB[i]));
    end
    o_rNext = w_carry ? w_diff : w_shift[WIDTH-1:0];
    o_qNext = {i_q[WIDTH-2:0], w_carry};
  end

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for MIPS32 DIV/DIVU; quotient -> LO, remainder -> HI.
// Signed operands are divided as magnitudes and the signs are restored in FIX.
// Optional feature: define DIVIDER_ABORT_EN to add an abort input that cancels
// an operation in RUN or FIX without a done pulse and without touching results.
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mips_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       r_state;
  div_state_e       w_stateNext;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_negQ;
  logic             r_negR;
  logic             r_dbz;
  logic             w_accept;
  logic             w_abort;
  logic             w_lastStep;
  logic             w_divZero;
  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;

`ifdef DIVIDER_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept   = bus.start && ((r_state == DIV_IDLE) || (r_state == DIV_DONE));
  assign w_divZero  = (bus.divisor == '0);
  assign w_lastStep = (r_count == CW'(WIDTH - 1));
  assign w_magA     = (bus.sign_en && bus.dividend[WIDTH-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_magB     = (bus.sign_en && bus.divisor[WIDTH-1])  ? (~bus.divisor + 1'b1)  : bus.divisor;

  assign bus.busy        = (r_state == DIV_RUN) || (r_state == DIV_FIX);
  assign bus.done        = (r_state == DIV_DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

  mips_divider_step #(.WIDTH(WIDTH)) u_step (
    .i_r     (r_rem),
    .i_q     (r_quo),
    .i_d     (r_div),
    .o_rNext (w_remNext),
    .o_qNext (w_quoNext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: a zero divisor skips straight to DONE; abort beats step completion
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      DIV_IDLE, DIV_DONE: begin
        w_stateNext = DIV_IDLE;
        if (w_accept) begin
          w_stateNext = w_divZero ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (w_abort) begin
          w_stateNext = DIV_IDLE;
        end else if (w_lastStep) begin
          w_stateNext = DIV_FIX;
        end
      end
      DIV_FIX: begin
        w_stateNext = w_abort ? DIV_IDLE : DIV_DONE;
      end
      default: w_stateNext = DIV_IDLE;
    endcase
  end

  // Operand capture, per-step update of {R,Q}, and sign fix-up of the results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_dbz   <= w_divZero;
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= w_magA;
      r_div   <= w_magB;
      r_negQ  <= bus.sign_en & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_negR  <= bus.sign_en & bus.dividend[WIDTH-1];
      if (w_divZero) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend;
      end
    end else if ((r_state == DIV_RUN) && !w_abort) begin
      r_rem   <= w_remNext;
      r_quo   <= w_quoNext;
      r_count <= r_count + 1'b1;
    end else if ((r_state == DIV_FIX) && !w_abort) begin
      r_quotient  <= r_negQ ? (~r_quo + 1'b1) : r_quo;
      r_remainder <= r_negR ? (~r_rem + 1'b1) : r_rem;
    end
  end

endmodule
